// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM stage of the pipeline.
//
// Purpose:
//   Issues one data-bus transaction for every load or store sitting in the
//   EX_MEM register. While the transaction is in flight, it freezes the earlier
//   stages, then hands the registered writeback bundle to MEM_WB.
//   Instructions that do not access memory pass through with one cycle of
//   latency.
//
// Bus handshake:
//   dbus_req is a registered request. It rises on the IDLE->BUSY edge. While
//   it is high, dbus_we, dbus_addr, dbus_wstrb and dbus_wdata do not change.
//   The slave completes the transfer with a one-cycle dbus_ack pulse, and
//   dbus_rdata is valid in that same cycle. The ack is sampled only in BUSY.
//   The request is registered, so an ack cannot complete in the cycle the
//   request is first raised. The request drops on the edge that samples the
//   ack.
//
// Ports:
//   cpu_clk, cpu_rst        clock, asynchronous active-high reset
//   EX_MEM_*                instruction bundle from the EX/MEM register
//   dbus_req/we/addr/wstrb/wdata  data-bus request (registered)
//   dbus_ack/rdata          data-bus completion and read data
//   mem_stall               freezes IF/ID/EX and the EX_MEM register
//   MEM_WB_rf_we/wR/wd/pc   registered writeback bundle
//   mem_misalign            one-cycle misaligned-access pulse
//   dbg_state               current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Build option:
//   `define MEM_MISALIGN_CHK_EN enables misaligned-access detection. A
//   misaligned access then raises no bus request, pulses mem_misalign and
//   suppresses the register-file write. Without the macro, mem_misalign is
//   tied to 0 and offset bits below the access size are ignored.

module mem_access_unit (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   input  logic        EX_MEM_rf_we,
   input  logic [2:0]  EX_MEM_rf_wd_sel,
   input  logic        EX_MEM_ram_we,
   input  logic [1:0]  EX_MEM_ram_op,
   input  logic [1:0]  EX_MEM_sext2_op,
   input  logic [31:0] EX_MEM_pc,
   input  logic [31:0] EX_MEM_alu_c,
   input  logic [31:0] EX_MEM_alu_f,
   input  logic [31:0] EX_MEM_rd1,
   input  logic [4:0]  EX_MEM_wR,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_wstrb,
   output logic [31:0] dbus_wdata,
   input  logic        dbus_ack,
   input  logic [31:0] dbus_rdata,
   output logic        mem_stall,
   output logic        MEM_WB_rf_we,
   output logic [4:0]  MEM_WB_wR,
   output logic [31:0] MEM_WB_wd,
   output logic [31:0] MEM_WB_pc,
   output logic        mem_misalign,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic        dbus_req_q, dbus_req_d;
   logic        dbus_we_q, dbus_we_d;
   logic [31:0] dbus_addr_q, dbus_addr_d;
   logic [3:0]  dbus_wstrb_q, dbus_wstrb_d;
   logic [31:0] dbus_wdata_q, dbus_wdata_d;
   logic [31:0] load_q, load_d;
   logic        wb_rf_we_q, wb_rf_we_d;
   logic [4:0]  wb_wr_q, wb_wr_d;
   logic [31:0] wb_wd_q, wb_wd_d;
   logic [31:0] wb_pc_q, wb_pc_d;

   logic        is_half, is_byte, is_word;
   logic        access_raw, misalign, access;
   logic [3:0]  strb_c;
   logic [31:0] wdata_c;
   logic [4:0]  shamt;
   logic [31:0] shifted;
   logic [31:0] load_ext;
   logic [31:0] wd_sel_c;
   logic        unused_sext_hi;

   // Only bit 0 of the extension select carries meaning.
   assign unused_sext_hi = EX_MEM_sext2_op[1];

   assign is_half = (EX_MEM_ram_op == 2'd1);
   assign is_byte = (EX_MEM_ram_op == 2'd2);
   assign is_word = !is_half && !is_byte;   // size code 3 also behaves as word

   assign access_raw = EX_MEM_ram_we || (EX_MEM_rf_wd_sel == 3'd2);

`ifdef MEM_MISALIGN_CHK_EN
   assign misalign = access_raw &&
                     ((is_half && EX_MEM_alu_c[0]) ||
                      (is_word && (EX_MEM_alu_c[1:0] != 2'b00)));
`else
   assign misalign = 1'b0;
`endif

   assign access    = access_raw && !misalign;
   assign mem_stall = access && (state_q != DONE);

   // Byte lanes and replicated store data.
   always_comb begin
      strb_c  = 4'b1111;
      wdata_c = EX_MEM_rd1;
      shamt   = 5'd0;
      if (is_byte) begin
         strb_c  = 4'b0001 << EX_MEM_alu_c[1:0];
         wdata_c = {4{EX_MEM_rd1[7:0]}};
         shamt   = {EX_MEM_alu_c[1:0], 3'b000};
      end else if (is_half) begin
         strb_c  = EX_MEM_alu_c[1] ? 4'b1100 : 4'b0011;
         wdata_c = {2{EX_MEM_rd1[15:0]}};
         shamt   = {EX_MEM_alu_c[1], 4'b0000};
      end
   end

   // Move the addressed lane down to bit 0, then extend it.
   assign shifted = dbus_rdata >> shamt;

   always_comb begin
      load_ext = shifted;
      if (is_byte) begin
         load_ext = EX_MEM_sext2_op[0] ? {24'd0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      end else if (is_half) begin
         load_ext = EX_MEM_sext2_op[0] ? {16'd0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      end
   end

   always_comb begin
      case (EX_MEM_rf_wd_sel)
         3'd1:    wd_sel_c = EX_MEM_pc + 32'd4;
         3'd2:    wd_sel_c = load_q;
         3'd3:    wd_sel_c = EX_MEM_alu_f;
         default: wd_sel_c = EX_MEM_alu_c;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      dbus_req_d   = dbus_req_q;
      dbus_we_d    = dbus_we_q;
      dbus_addr_d  = dbus_addr_q;
      dbus_wstrb_d = dbus_wstrb_q;
      dbus_wdata_d = dbus_wdata_q;
      load_d       = load_q;
      wb_rf_we_d   = wb_rf_we_q;
      wb_wr_d      = wb_wr_q;
      wb_wd_d      = wb_wd_q;
      wb_pc_d      = wb_pc_q;
      case (state_q)
         IDLE: begin
            if (access) begin
               state_d      = BUSY;
               dbus_req_d   = 1'b1;
               dbus_we_d    = EX_MEM_ram_we;
               dbus_addr_d  = {EX_MEM_alu_c[31:2], 2'b00};
               dbus_wstrb_d = strb_c;
               dbus_wdata_d = wdata_c;
               wb_rf_we_d   = 1'b0;           // bubble while the access runs
            end else begin
               wb_rf_we_d = EX_MEM_rf_we && !misalign;
               wb_wr_d    = EX_MEM_wR;
               wb_wd_d    = wd_sel_c;
               wb_pc_d    = EX_MEM_pc;
            end
         end
         BUSY: begin
            wb_rf_we_d = 1'b0;
            if (dbus_ack) begin
               state_d    = DONE;
               dbus_req_d = 1'b0;
               load_d     = load_ext;
            end
         end
         DONE: begin
            // EX_MEM is still frozen here, so it still holds this access.
            state_d    = IDLE;
            wb_rf_we_d = EX_MEM_rf_we;
            wb_wr_d    = EX_MEM_wR;
            wb_wd_d    = wd_sel_c;
            wb_pc_d    = EX_MEM_pc;
         end
         default: begin
            state_d    = IDLE;
            dbus_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         state_q      <= IDLE;
         dbus_req_q   <= 1'b0;
         dbus_we_q    <= 1'b0;
         dbus_addr_q  <= 32'd0;
         dbus_wstrb_q <= 4'd0;
         dbus_wdata_q <= 32'd0;
         load_q       <= 32'd0;
         wb_rf_we_q   <= 1'b0;
         wb_wr_q      <= 5'd0;
         wb_wd_q      <= 32'd0;
         wb_pc_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         dbus_req_q   <= dbus_req_d;
         dbus_we_q    <= dbus_we_d;
         dbus_addr_q  <= dbus_addr_d;
         dbus_wstrb_q <= dbus_wstrb_d;
         dbus_wdata_q <= dbus_wdata_d;
         load_q       <= load_d;
         wb_rf_we_q   <= wb_rf_we_d;
         wb_wr_q      <= wb_wr_d;
         wb_wd_q      <= wb_wd_d;
         wb_pc_q      <= wb_pc_d;
      end
   end

`ifdef MEM_MISALIGN_CHK_EN
   logic mem_misalign_q, mem_misalign_d;

   // The pulse is registered. The pipeline is not stalled, so the
   // instruction leaves EX_MEM after one cycle.
   assign mem_misalign_d = (state_q == IDLE) && misalign;

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) mem_misalign_q <= 1'b0;
      else         mem_misalign_q <= mem_misalign_d;
   end

   assign mem_misalign = mem_misalign_q;
`else
   assign mem_misalign = 1'b0;
`endif

   assign dbus_req     = dbus_req_q;
   assign dbus_we      = dbus_we_q;
   assign dbus_addr    = dbus_addr_q;
   assign dbus_wstrb   = dbus_wstrb_q;
   assign dbus_wdata   = dbus_wdata_q;
   assign MEM_WB_rf_we = wb_rf_we_q;
   assign MEM_WB_wR    = wb_wr_q;
   assign MEM_WB_wd    = wb_wd_q;
   assign MEM_WB_pc    = wb_pc_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit -- directed bench for mem_access_unit.
// It checks reset values, pass-through writeback, loads of each size and
// extension, stores of each size, reset during BUSY, and misaligned-access
// handling in both builds.

module tb_mem_access_unit;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst;
   logic        EX_MEM_rf_we;
   logic [2:0]  EX_MEM_rf_wd_sel;
   logic        EX_MEM_ram_we;
   logic [1:0]  EX_MEM_ram_op;
   logic [1:0]  EX_MEM_sext2_op;
   logic [31:0] EX_MEM_pc;
   logic [31:0] EX_MEM_alu_c;
   logic [31:0] EX_MEM_alu_f;
   logic [31:0] EX_MEM_rd1;
   logic [4:0]  EX_MEM_wR;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_wstrb;
   logic [31:0] dbus_wdata;
   logic        dbus_ack;
   logic [31:0] dbus_rdata;
   logic        mem_stall;
   logic        MEM_WB_rf_we;
   logic [4:0]  MEM_WB_wR;
   logic [31:0] MEM_WB_wd;
   logic [31:0] MEM_WB_pc;
   logic        mem_misalign;
   logic [1:0]  dbg_state;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];

   mem_access_unit dut (
      .cpu_clk          (cpu_clk),
      .cpu_rst          (cpu_rst),
      .EX_MEM_rf_we     (EX_MEM_rf_we),
      .EX_MEM_rf_wd_sel (EX_MEM_rf_wd_sel),
      .EX_MEM_ram_we    (EX_MEM_ram_we),
      .EX_MEM_ram_op    (EX_MEM_ram_op),
      .EX_MEM_sext2_op  (EX_MEM_sext2_op),
      .EX_MEM_pc        (EX_MEM_pc),
      .EX_MEM_alu_c     (EX_MEM_alu_c),
      .EX_MEM_alu_f     (EX_MEM_alu_f),
      .EX_MEM_rd1       (EX_MEM_rd1),
      .EX_MEM_wR        (EX_MEM_wR),
      .dbus_req         (dbus_req),
      .dbus_we          (dbus_we),
      .dbus_addr        (dbus_addr),
      .dbus_wstrb       (dbus_wstrb),
      .dbus_wdata       (dbus_wdata),
      .dbus_ack         (dbus_ack),
      .dbus_rdata       (dbus_rdata),
      .mem_stall        (mem_stall),
      .MEM_WB_rf_we     (MEM_WB_rf_we),
      .MEM_WB_wR        (MEM_WB_wR),
      .MEM_WB_wd        (MEM_WB_wd),
      .MEM_WB_pc        (MEM_WB_pc),
      .mem_misalign     (mem_misalign),
      .dbg_state        (dbg_state)
   );

   // Clock and reset.
   always #5 cpu_clk = ~cpu_clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic drive(input logic rf_we, input logic [2:0] sel, input logic ram_we,
                        input logic [1:0] op, input logic [1:0] sext, input logic [31:0] pc,
                        input logic [31:0] alu_c, input logic [31:0] rd1, input logic [4:0] wr);
      EX_MEM_rf_we     = rf_we;
      EX_MEM_rf_wd_sel = sel;
      EX_MEM_ram_we    = ram_we;
      EX_MEM_ram_op    = op;
      EX_MEM_sext2_op  = sext;
      EX_MEM_pc        = pc;
      EX_MEM_alu_c     = alu_c;
      EX_MEM_rd1       = rd1;
      EX_MEM_wR        = wr;
   endtask

   // The access is already driven in IDLE. This task runs the transfer up to
   // the DONE->IDLE edge. It checks that the bus fields stay stable in every
   // BUSY cycle and acks in the wait_n-th BUSY cycle.
   task automatic run_access(input int wait_n, input logic [31:0] rd,
                             input logic e_we, input logic [31:0] e_addr,
                             input logic [3:0] e_strb, input logic [31:0] e_wdata);
      int req_cyc;
      int guard;
      req_cyc = 0;
      guard   = 0;
      #1;
      check_eq("stall_idle", mem_stall, 1);
      check_eq("req_idle", dbus_req, 0);
      tick;
      check_eq("bubble_rf_we", MEM_WB_rf_we, 0);
      while (dbus_req && guard < 40) begin
         guard++;
         req_cyc++;
         check_eq("stall_busy", mem_stall, 1);
         check_eq("bus_we", dbus_we, e_we);
         check_eq("bus_addr", dbus_addr, e_addr);
         check_eq("bus_wstrb", {28'd0, dbus_wstrb}, {28'd0, e_strb});
         check_eq("bus_wdata", dbus_wdata, e_wdata);
         if (req_cyc == wait_n) begin
            dbus_ack   = 1'b1;
            dbus_rdata = rd;
         end
         tick;
         dbus_ack   = 1'b0;
         dbus_rdata = 32'h5A5A_5A5A;
      end
      check_eq("req_cycles", req_cyc, wait_n);
      check_eq("state_done", {30'd0, dbg_state}, 2);
      check_eq("stall_done", mem_stall, 0);
      tick;
   endtask

   task automatic check_wb(input logic e_we, input logic [4:0] e_wr, input logic [31:0] e_pc);
      logic [31:0] e_wd;
      e_wd = exp_q.pop_front();
      check_eq("wb_wd", MEM_WB_wd, e_wd);
      check_eq("wb_rf_we", MEM_WB_rf_we, e_we);
      check_eq("wb_wr", {27'd0, MEM_WB_wR}, {27'd0, e_wr});
      check_eq("wb_pc", MEM_WB_pc, e_pc);
      check_eq("state_idle", {30'd0, dbg_state}, 0);
   endtask

   initial begin
      cpu_rst      = 1'b1;
      dbus_ack     = 1'b0;
      dbus_rdata   = 32'd0;
      EX_MEM_alu_f = 32'hF0F0_0003;
      drive(1'b0, 3'd0, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0);
      repeat (2) @(negedge cpu_clk);

      // Values while reset is asserted.
      check_eq("rst_req", dbus_req, 0);
      check_eq("rst_we", dbus_we, 0);
      check_eq("rst_addr", dbus_addr, 0);
      check_eq("rst_wstrb", {28'd0, dbus_wstrb}, 0);
      check_eq("rst_wdata", dbus_wdata, 0);
      check_eq("rst_wb_we", MEM_WB_rf_we, 0);
      check_eq("rst_wb_wd", MEM_WB_wd, 0);
      check_eq("rst_wb_pc", MEM_WB_pc, 0);
      check_eq("rst_misalign", mem_misalign, 0);
      check_eq("rst_stall", mem_stall, 0);
      cpu_rst = 1'b0;
      tick;

      // Pass-through PC+4 wraps to zero. A spurious ack in IDLE has no effect.
      drive(1'b1, 3'd1, 1'b0, 2'd0, 2'd0, 32'hFFFF_FFFC, 32'h0000_1111, 32'd0, 5'd7);
      dbus_ack = 1'b1;
      #1;
      check_eq("pt_stall", mem_stall, 0);
      exp_q.push_back(32'h0000_0000);
      tick;
      dbus_ack = 1'b0;
      check_wb(1'b1, 5'd7, 32'hFFFF_FFFC);
      check_eq("pt_req", dbus_req, 0);

      // Pass-through ALU_f select and an undefined select that falls back to ALU_C.
      drive(1'b1, 3'd3, 1'b0, 2'd0, 2'd0, 32'h0000_0010, 32'h1122_3344, 32'd0, 5'd3);
      exp_q.push_back(32'hF0F0_0003);
      tick;
      check_wb(1'b1, 5'd3, 32'h0000_0010);
      drive(1'b1, 3'd6, 1'b0, 2'd0, 2'd0, 32'h0000_0014, 32'h1122_3344, 32'd0, 5'd4);
      exp_q.push_back(32'h1122_3344);
      tick;
      check_wb(1'b1, 5'd4, 32'h0000_0014);

      // Load word at 0x100, acked in the 3rd BUSY cycle.
      drive(1'b1, 3'd2, 1'b0, 2'd0, 2'd0, 32'h0000_0040, 32'h0000_0100, 32'h1357_2468, 5'd5);
      exp_q.push_back(32'hDEAD_BEEF);
      run_access(3, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'b1111, 32'h1357_2468);
      check_wb(1'b1, 5'd5, 32'h0000_0040);

      // Signed load byte at 0x103.
      drive(1'b1, 3'd2, 1'b0, 2'd2, 2'd0, 32'h0000_0044, 32'h0000_0103, 32'd0, 5'd6);
      exp_q.push_back(32'hFFFF_FF80);
      run_access(1, 32'h80FF_FFFF, 1'b0, 32'h0000_0100, 4'b1000, 32'd0);
      check_wb(1'b1, 5'd6, 32'h0000_0044);

      // The same byte load, zero-extended.
      drive(1'b1, 3'd2, 1'b0, 2'd2, 2'd1, 32'h0000_0048, 32'h0000_0103, 32'd0, 5'd6);
      exp_q.push_back(32'h0000_0080);
      run_access(2, 32'h80FF_FFFF, 1'b0, 32'h0000_0100, 4'b1000, 32'd0);
      check_wb(1'b1, 5'd6, 32'h0000_0048);

      // Signed half from the upper lane, then a zero-extended half from the lower lane.
      drive(1'b1, 3'd2, 1'b0, 2'd1, 2'd0, 32'h0000_004C, 32'h0000_0102, 32'd0, 5'd8);
      exp_q.push_back(32'hFFFF_8001);
      run_access(1, 32'h8001_1234, 1'b0, 32'h0000_0100, 4'b1100, 32'd0);
      check_wb(1'b1, 5'd8, 32'h0000_004C);
      drive(1'b1, 3'd2, 1'b0, 2'd1, 2'd1, 32'h0000_0050, 32'h0000_0100, 32'd0, 5'd9);
      exp_q.push_back(32'h0000_F00D);
      run_access(1, 32'h1234_F00D, 1'b0, 32'h0000_0100, 4'b0011, 32'd0);
      check_wb(1'b1, 5'd9, 32'h0000_0050);

      // Store half at 0x202.
      drive(1'b0, 3'd0, 1'b1, 2'd1, 2'd0, 32'h0000_0054, 32'h0000_0202, 32'h1234_ABCD, 5'd0);
      exp_q.push_back(32'h0000_0202);
      run_access(2, 32'd0, 1'b1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
      check_wb(1'b0, 5'd0, 32'h0000_0054);

      // Store byte at 0x201, then a store with size code 3 (word).
      drive(1'b0, 3'd0, 1'b1, 2'd2, 2'd0, 32'h0000_0058, 32'h0000_0201, 32'h0000_00A5, 5'd0);
      exp_q.push_back(32'h0000_0201);
      run_access(1, 32'd0, 1'b1, 32'h0000_0200, 4'b0010, 32'hA5A5_A5A5);
      check_wb(1'b0, 5'd0, 32'h0000_0058);
      drive(1'b0, 3'd0, 1'b1, 2'd3, 2'd0, 32'h0000_005C, 32'h0000_0300, 32'hCAFE_F00D, 5'd0);
      exp_q.push_back(32'h0000_0300);
      run_access(1, 32'd0, 1'b1, 32'h0000_0300, 4'b1111, 32'hCAFE_F00D);
      check_wb(1'b0, 5'd0, 32'h0000_005C);

`ifdef MEM_MISALIGN_CHK_EN
      // Misaligned load word: no request, one-cycle pulse, write suppressed.
      drive(1'b1, 3'd2, 1'b0, 2'd0, 2'd0, 32'h0000_0060, 32'h0000_0101, 32'd0, 5'd10);
      #1;
      check_eq("mis_stall", mem_stall, 0);
      tick;
      check_eq("mis_pulse", mem_misalign, 1);
      check_eq("mis_req", dbus_req, 0);
      check_eq("mis_rf_we", MEM_WB_rf_we, 0);
      check_eq("mis_state", {30'd0, dbg_state}, 0);
      drive(1'b0, 3'd0, 1'b0, 2'd0, 2'd0, 32'h0000_0064, 32'd0, 32'd0, 5'd0);
      tick;
      check_eq("mis_pulse_end", mem_misalign, 0);
`else
      // Without the checker, a word at 0x101 is treated as the word at 0x100.
      drive(1'b1, 3'd2, 1'b0, 2'd0, 2'd0, 32'h0000_0060, 32'h0000_0101, 32'd0, 5'd10);
      exp_q.push_back(32'h1122_3344);
      run_access(1, 32'h1122_3344, 1'b0, 32'h0000_0100, 4'b1111, 32'd0);
      check_wb(1'b1, 5'd10, 32'h0000_0060);
      check_eq("mis_tied", mem_misalign, 0);
`endif

      // Reset asserted during BUSY clears everything at once.
      drive(1'b0, 3'd0, 1'b1, 2'd0, 2'd0, 32'h0000_0070, 32'h0000_0400, 32'h0000_0077, 5'd0);
      tick;
      check_eq("pre_rst_req", dbus_req, 1);
      #2;
      cpu_rst = 1'b1;
      #1;
      check_eq("mrst_req", dbus_req, 0);
      check_eq("mrst_we", dbus_we, 0);
      check_eq("mrst_addr", dbus_addr, 0);
      check_eq("mrst_wstrb", {28'd0, dbus_wstrb}, 0);
      check_eq("mrst_wdata", dbus_wdata, 0);
      check_eq("mrst_wb_pc", MEM_WB_pc, 0);
      check_eq("mrst_wb_wd", MEM_WB_wd, 0);
      check_eq("mrst_state", {30'd0, dbg_state}, 0);

      // A stale ack around reset release must not be honoured.
      drive(1'b0, 3'd0, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0);
      dbus_ack = 1'b1;
      @(negedge cpu_clk);
      cpu_rst = 1'b0;
      tick;
      check_eq("post_rst_state", {30'd0, dbg_state}, 0);
      check_eq("post_rst_req", dbus_req, 0);
      dbus_ack = 1'b0;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
